// File: rtl/argmax_scan.sv
`default_nettype none
// ============================================================================
// Module   : argmax_scan
// Brief    : Scans a RAM window and tracks the largest and second-largest
//            entries with their addresses.
// Revision : 1.0
// ============================================================================

module argmax_scan #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int SIGNED     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] len,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] max,
  output logic [ADDR_WIDTH-1:0] max_idx,
  output logic [DATA_WIDTH-1:0] second,
  output logic [ADDR_WIDTH-1:0] second_idx,
  output logic                  second_valid
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2:0]            DRAIN_INIT = 3'(RD_LATENCY - 1);
  localparam logic [DATA_WIDTH-1:0] TYPE_MIN   = (SIGNED != 0) ?
                                                 {1'b1, {(DATA_WIDTH-1){1'b0}}} :
                                                 {DATA_WIDTH{1'b0}};

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   issue_left;
  logic [2:0]              drain_left;
  logic [RD_LATENCY-1:0]   pipe_vld;
  logic [ADDR_WIDTH-1:0]   pipe_addr [RD_LATENCY];
  logic                    first_pending;
  logic                    smp_vld;
  logic [ADDR_WIDTH-1:0]   smp_addr;

  function automatic logic greater(input logic [DATA_WIDTH-1:0] a,
                                   input logic [DATA_WIDTH-1:0] b);
    if (SIGNED != 0) return $signed(a) > $signed(b);
    else             return a > b;
  endfunction

  // issue_left counts reads still to issue after the current one, so a
  // zero length (full 2^ADDR_WIDTH window) loads all ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      issue_left <= '0;
      drain_left <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state      <= S_ISSUE;
            busy       <= 1'b1;
            rd_en      <= 1'b1;
            rd_addr    <= base_addr;
            issue_left <= (len == '0) ? '1 : len - ADDR_ONE;
          end
        end
        S_ISSUE: begin
          if (issue_left == '0) begin
            rd_en      <= 1'b0;
            drain_left <= DRAIN_INIT;
            state      <= S_DRAIN;
          end else begin
            rd_addr    <= rd_addr + ADDR_ONE;
            issue_left <= issue_left - ADDR_ONE;
          end
        end
        S_DRAIN: begin
          if (drain_left == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            drain_left <= drain_left - 3'd1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Valid/address tag travels alongside the RAM access latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= rd_en;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
      end
    end
    pipe_addr[0] <= rd_addr;
    for (int i = 1; i < RD_LATENCY; i++) begin
      pipe_addr[i] <= pipe_addr[i-1];
    end
  end

  assign smp_vld  = pipe_vld[RD_LATENCY-1];
  assign smp_addr = pipe_addr[RD_LATENCY-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      max           <= '0;
      max_idx       <= '0;
      second        <= '0;
      second_idx    <= '0;
      second_valid  <= 1'b0;
      first_pending <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        first_pending <= 1'b1;
      end
      if (smp_vld) begin
        if (first_pending) begin
          first_pending <= 1'b0;
          max           <= rd_data;
          max_idx       <= smp_addr;
          second        <= TYPE_MIN;
          second_idx    <= '0;
          second_valid  <= 1'b0;
        end else begin
          // Strict compare keeps the earliest peak; an equal later sample
          // falls through to become the runner-up.
          if (greater(rd_data, max)) begin
            second     <= max;
            second_idx <= max_idx;
            max        <= rd_data;
            max_idx    <= smp_addr;
          end else if (greater(rd_data, second) || !second_valid) begin
            second     <= rd_data;
            second_idx <= smp_addr;
          end
          second_valid <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_argmax_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_argmax_scan
// Brief    : Directed self-checking bench for argmax_scan.
// Revision : 1.0
// ============================================================================

module tb_argmax_scan;

  localparam int NI = 5;  // 0..3: RD_LATENCY 1..4 signed, 4: latency 1 unsigned

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_s      [NI];
  logic [7:0]  base_s       [NI];
  logic [7:0]  len_s        [NI];
  logic        busy_s       [NI];
  logic        done_s       [NI];
  logic        rd_en_s      [NI];
  logic [7:0]  rd_addr_s    [NI];
  logic [31:0] rd_data_s    [NI];
  logic [31:0] max_s        [NI];
  logic [7:0]  max_idx_s    [NI];
  logic [31:0] second_s     [NI];
  logic [7:0]  second_idx_s [NI];
  logic        sv_s         [NI];

  logic [31:0] mem [256];
  logic [7:0]  addr_log [512];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int LAT = (g < 4) ? g + 1 : 1;
      localparam int SGN = (g < 4) ? 1 : 0;
      logic [31:0] dp [4];

      argmax_scan #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .RD_LATENCY(LAT), .SIGNED(SGN)
      ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start_s[g]),
        .base_addr(base_s[g]), .len(len_s[g]),
        .busy(busy_s[g]), .done(done_s[g]),
        .rd_en(rd_en_s[g]), .rd_addr(rd_addr_s[g]), .rd_data(rd_data_s[g]),
        .max(max_s[g]), .max_idx(max_idx_s[g]),
        .second(second_s[g]), .second_idx(second_idx_s[g]),
        .second_valid(sv_s[g])
      );

      always @(posedge clk) begin
        dp[0] <= mem[rd_addr_s[g]];
        for (int k = 1; k < 4; k++) dp[k] <= dp[k-1];
      end
      assign rd_data_s[g] = dp[LAT-1];
    end
  endgenerate

  // Starts a scan at the first idle edge, then returns in the done cycle (+1).
  task automatic run_scan(input int inst, input logic [7:0] b, input logic [7:0] l,
                          input int abuse_cyc, output int done_cyc, output int rden_cnt,
                          output logic busy1, output logic busy_at_done);
    done_cyc = -1; rden_cnt = 0; busy1 = 1'b0; busy_at_done = 1'b1;
    @(posedge clk); #1;
    base_s[inst] = b; len_s[inst] = l; start_s[inst] = 1'b1;
    @(posedge clk); #1;
    start_s[inst] = 1'b0;
    for (int cyc = 1; cyc < 2000; cyc++) begin
      if (cyc == 1) busy1 = busy_s[inst];
      if (rd_en_s[inst]) begin
        if (rden_cnt < 512) addr_log[rden_cnt] = rd_addr_s[inst];
        rden_cnt++;
      end
      if (cyc == abuse_cyc) begin
        base_s[inst] = 8'd100; len_s[inst] = 8'd3; start_s[inst] = 1'b1;
      end else begin
        start_s[inst] = 1'b0;
      end
      if (done_s[inst]) begin
        done_cyc = cyc; busy_at_done = busy_s[inst];
        break;
      end
      @(posedge clk); #1;
    end
    start_s[inst] = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (busy_s[0] !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", busy_s[0]); end
    checks++; if (done_s[0] !== 1'b0) begin errors++; $display("FAIL rst_done got %0b exp 0", done_s[0]); end
    checks++; if (rd_en_s[0] !== 1'b0) begin errors++; $display("FAIL rst_rd_en got %0b exp 0", rd_en_s[0]); end
    checks++; if ({rd_addr_s[0], max_s[0], max_idx_s[0], second_s[0], second_idx_s[0], sv_s[0]} !== 81'd0) begin
      errors++; $display("FAIL rst_results got addr=%0h max=%0h/%0h sec=%0h/%0h sv=%0b exp all 0",
                         rd_addr_s[0], max_s[0], max_idx_s[0], second_s[0], second_idx_s[0], sv_s[0]);
    end
  endtask

  task automatic test_ramp();
    int dc, rc; logic b1, bd;
    for (int i = 0; i < 256; i++) mem[i] = 32'(i);
    run_scan(0, 8'd0, 8'd0, -1, dc, rc, b1, bd);
    checks++; if (max_s[0] !== 32'd255) begin errors++; $display("FAIL ramp_max got %0d exp 255", max_s[0]); end
    checks++; if (max_idx_s[0] !== 8'd255) begin errors++; $display("FAIL ramp_max_idx got %0d exp 255", max_idx_s[0]); end
    checks++; if (second_s[0] !== 32'd254) begin errors++; $display("FAIL ramp_second got %0d exp 254", second_s[0]); end
    checks++; if (second_idx_s[0] !== 8'd254) begin errors++; $display("FAIL ramp_second_idx got %0d exp 254", second_idx_s[0]); end
    checks++; if (sv_s[0] !== 1'b1) begin errors++; $display("FAIL ramp_sv got %0b exp 1", sv_s[0]); end
    checks++; if (dc !== 258) begin errors++; $display("FAIL ramp_done_cycle got %0d exp 258", dc); end
    checks++; if (rc !== 256) begin errors++; $display("FAIL ramp_rd_en_count got %0d exp 256", rc); end
    checks++; if (b1 !== 1'b1 || bd !== 1'b0) begin errors++; $display("FAIL ramp_busy got c1=%0b done=%0b exp 1/0", b1, bd); end
  endtask

  task automatic test_signed();
    int dc, rc; logic b1, bd;
    for (int i = 0; i < 16; i++) mem[i] = 32'hFFFF_FFFB;
    mem[7] = 32'hFFFF_FFFE;
    mem[9] = 32'hFFFF_FFFD;
    run_scan(0, 8'd0, 8'd16, -1, dc, rc, b1, bd);
    checks++; if (max_s[0] !== 32'hFFFF_FFFE || max_idx_s[0] !== 8'd7) begin
      errors++; $display("FAIL signed_max got %0h@%0d exp fffffffe@7", max_s[0], max_idx_s[0]); end
    checks++; if (second_s[0] !== 32'hFFFF_FFFD || second_idx_s[0] !== 8'd9) begin
      errors++; $display("FAIL signed_second got %0h@%0d exp fffffffd@9", second_s[0], second_idx_s[0]); end
    run_scan(4, 8'd0, 8'd16, -1, dc, rc, b1, bd);
    checks++; if (max_s[4] !== 32'hFFFF_FFFE || max_idx_s[4] !== 8'd7) begin
      errors++; $display("FAIL unsigned_max got %0h@%0d exp fffffffe@7", max_s[4], max_idx_s[4]); end
    checks++; if (second_s[4] !== 32'hFFFF_FFFD || second_idx_s[4] !== 8'd9) begin
      errors++; $display("FAIL unsigned_second got %0h@%0d exp fffffffd@9", second_s[4], second_idx_s[4]); end
  endtask

  task automatic test_ties();
    int dc, rc; logic b1, bd;
    for (int i = 0; i < 16; i++) mem[i] = 32'd1;
    mem[3] = 32'd100; mem[12] = 32'd100;
    run_scan(0, 8'd0, 8'd16, -1, dc, rc, b1, bd);
    checks++; if (max_s[0] !== 32'd100 || max_idx_s[0] !== 8'd3) begin
      errors++; $display("FAIL ties_max got %0d@%0d exp 100@3", max_s[0], max_idx_s[0]); end
    checks++; if (second_s[0] !== 32'd100 || second_idx_s[0] !== 8'd12) begin
      errors++; $display("FAIL ties_second got %0d@%0d exp 100@12", second_s[0], second_idx_s[0]); end
    checks++; if (dc !== 18) begin errors++; $display("FAIL ties_done_cycle got %0d exp 18", dc); end
  endtask

  task automatic test_wrap_single();
    int dc, rc; logic b1, bd;
    for (int i = 0; i < 256; i++) mem[i] = 32'd1;
    mem[2] = 32'd50;
    run_scan(0, 8'd250, 8'd10, -1, dc, rc, b1, bd);
    checks++; if (max_s[0] !== 32'd50 || max_idx_s[0] !== 8'd2) begin
      errors++; $display("FAIL wrap_max got %0d@%0d exp 50@2", max_s[0], max_idx_s[0]); end
    checks++; if (second_s[0] !== 32'd1 || second_idx_s[0] !== 8'd250) begin
      errors++; $display("FAIL wrap_second got %0d@%0d exp 1@250", second_s[0], second_idx_s[0]); end
    checks++; if (rc !== 10 || addr_log[0] !== 8'd250 || addr_log[5] !== 8'd255 ||
                  addr_log[6] !== 8'd0 || addr_log[9] !== 8'd3) begin
      errors++; $display("FAIL wrap_addrs got n=%0d a0=%0d a5=%0d a6=%0d a9=%0d exp 10/250/255/0/3",
                         rc, addr_log[0], addr_log[5], addr_log[6], addr_log[9]); end
    mem[5] = 32'd77;
    run_scan(0, 8'd5, 8'd1, -1, dc, rc, b1, bd);
    checks++; if (max_s[0] !== 32'd77 || max_idx_s[0] !== 8'd5) begin
      errors++; $display("FAIL single_max got %0d@%0d exp 77@5", max_s[0], max_idx_s[0]); end
    checks++; if (sv_s[0] !== 1'b0 || second_s[0] !== 32'h8000_0000 || second_idx_s[0] !== 8'd0) begin
      errors++; $display("FAIL single_second got sv=%0b %0h@%0d exp 0 80000000@0",
                         sv_s[0], second_s[0], second_idx_s[0]); end
    checks++; if (dc !== 3) begin errors++; $display("FAIL single_done_cycle got %0d exp 3", dc); end
  endtask

  task automatic test_latency();
    int dc, rc; logic b1, bd;
    mem[0] = 32'd5; mem[1] = 32'd9;  mem[2] = 32'd2; mem[3] = 32'd40;
    mem[4] = 32'd7; mem[5] = 32'd33; mem[6] = 32'd1; mem[7] = 32'd8;
    for (int n = 0; n < 4; n++) begin
      run_scan(n, 8'd0, 8'd8, -1, dc, rc, b1, bd);
      checks++; if (dc !== 10 + n) begin errors++; $display("FAIL lat%0d_done_cycle got %0d exp %0d", n + 1, dc, 10 + n); end
      checks++; if (rc !== 8) begin errors++; $display("FAIL lat%0d_rd_en_count got %0d exp 8", n + 1, rc); end
      checks++; if (max_s[n] !== 32'd40 || max_idx_s[n] !== 8'd3 || second_s[n] !== 32'd33 || second_idx_s[n] !== 8'd5) begin
        errors++; $display("FAIL lat%0d_result got %0d@%0d %0d@%0d exp 40@3 33@5",
                           n + 1, max_s[n], max_idx_s[n], second_s[n], second_idx_s[n]); end
    end
  endtask

  task automatic test_handshake_abuse();
    int dc, rc; logic b1, bd;
    for (int i = 0; i < 256; i++) mem[i] = 32'(i);
    run_scan(0, 8'd0, 8'd8, 3, dc, rc, b1, bd);
    checks++; if (dc !== 10 || rc !== 8 || max_s[0] !== 32'd7 || max_idx_s[0] !== 8'd7) begin
      errors++; $display("FAIL issue_start got done=%0d n=%0d max=%0d@%0d exp 10/8/7@7",
                         dc, rc, max_s[0], max_idx_s[0]); end
    // Start raised in the done cycle must not be taken.
    base_s[0] = 8'd50; len_s[0] = 8'd2; start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    checks++; if (busy_s[0] !== 1'b0) begin errors++; $display("FAIL done_start got busy=%0b exp 0", busy_s[0]); end
  endtask

  task automatic test_back_to_back();
    int dc, rc; logic b1, bd;
    run_scan(0, 8'd0, 8'd4, -1, dc, rc, b1, bd);
    checks++; if (max_s[0] !== 32'd3 || dc !== 6) begin
      errors++; $display("FAIL b2b_first got max=%0d done=%0d exp 3/6", max_s[0], dc); end
    run_scan(0, 8'd10, 8'd3, -1, dc, rc, b1, bd);
    checks++; if (max_s[0] !== 32'd12 || max_idx_s[0] !== 8'd12 || second_s[0] !== 32'd11 || second_idx_s[0] !== 8'd11) begin
      errors++; $display("FAIL b2b_second_result got %0d@%0d %0d@%0d exp 12@12 11@11",
                         max_s[0], max_idx_s[0], second_s[0], second_idx_s[0]); end
    checks++; if (dc !== 5) begin errors++; $display("FAIL b2b_second_done got %0d exp 5", dc); end
  endtask

  task automatic test_reset_abort();
    int dc, rc, dones; logic b1, bd;
    for (int i = 0; i < 256; i++) mem[i] = 32'(i);
    @(posedge clk); #1;
    base_s[0] = 8'd0; len_s[0] = 8'd200; start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checks++; if (busy_s[0] !== 1'b1) begin errors++; $display("FAIL abort_mid_busy got %0b exp 1", busy_s[0]); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if ({busy_s[0], done_s[0], rd_en_s[0], rd_addr_s[0], max_s[0], max_idx_s[0],
                   second_s[0], second_idx_s[0], sv_s[0]} !== 84'd0) begin
      errors++; $display("FAIL abort_outputs got busy=%0b rd_en=%0b addr=%0h max=%0h/%0h sec=%0h/%0h sv=%0b exp all 0",
                         busy_s[0], rd_en_s[0], rd_addr_s[0], max_s[0], max_idx_s[0],
                         second_s[0], second_idx_s[0], sv_s[0]); end
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done_s[0] || busy_s[0]) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL abort_no_done got %0d active cycles exp 0", dones); end
    run_scan(0, 8'd0, 8'd8, -1, dc, rc, b1, bd);
    checks++; if (dc !== 10 || max_s[0] !== 32'd7 || second_s[0] !== 32'd6 || second_idx_s[0] !== 8'd6) begin
      errors++; $display("FAIL abort_rescan got done=%0d max=%0d sec=%0d@%0d exp 10/7/6@6",
                         dc, max_s[0], second_s[0], second_idx_s[0]); end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      start_s[i] = 1'b0; base_s[i] = 8'd0; len_s[i] = 8'd0;
    end
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_ramp();
    test_signed();
    test_ties();
    test_wrap_single();
    test_latency();
    test_handshake_abuse();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/argmax_scan.md
# argmax_scan

Parametrised successor to the single-shot argmax engine. It scans a programmable-length window of a synchronous-read RAM on request, tracking the largest and second-largest entries and their addresses. Scans are restartable: a start/busy/done handshake runs one scan per request, and there is no one-shot standby after reset. It sits between the beamformer power RAM and the steering controller, which uses the peak and runner-up for direction selection and peak-confidence checks.

## Interface
- DATA_WIDTH, 32, RAM word width
- ADDR_WIDTH, 8, RAM address width; max window 2^ADDR_WIDTH
- RD_LATENCY, 1, RAM read latency in cycles (1..4)
- SIGNED, 1, 1 = two's-complement compare, 0 = unsigned compare

- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle request to begin a scan; sampled only in IDLE
- base_addr  in  ADDR_WIDTH  first address of window; latched on accepted start
- len  in  ADDR_WIDTH  window length; 0 means 2^ADDR_WIDTH; latched on accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse; results valid and held from this cycle
- rd_en  out  1  RAM read strobe
- rd_addr  out  ADDR_WIDTH  RAM read address; wraps modulo 2^ADDR_WIDTH
- rd_data  in  DATA_WIDTH  RAM data, valid RD_LATENCY cycles after rd_en
- max  out  DATA_WIDTH  largest value in window
- max_idx  out  ADDR_WIDTH  address of first occurrence of max
- second  out  DATA_WIDTH  second-largest value; equals max if max occurs twice
- second_idx  out  ADDR_WIDTH  address of second
- second_valid  out  1  high if window held at least 2 entries

## Operation
- FSM states:
  - IDLE: on start, latch base_addr and len, then go to ISSUE.
  - ISSUE: drive rd_en=1 for exactly N cycles (N = len, or 2^ADDR_WIDTH when len=0), with rd_addr = base_addr + k for k = 0..N-1, modulo wrap. After the last issue, go to DRAIN.
  - DRAIN: wait until the last read returns, then go to DONE.
  - DONE: assert done for one cycle, then go to IDLE.
- Issued reads travel through a RD_LATENCY-deep shift register that carries a valid bit and the address. Comparison happens only when the valid bit emerges.
- First returned sample: max ← d, max_idx ← addr, second ← type minimum (0 unsigned, 100..0 signed), second_idx ← 0, second_valid ← 0.
- Each later sample d at address a:
  - if d > max: second ← max, second_idx ← max_idx, max ← d, max_idx ← a.
  - else if d > second, or second_valid = 0: second ← d, second_idx ← a.
  - set second_valid ← 1.
- Strict > on max means ties keep the earliest address. A later sample equal to max becomes the runner-up.
- The compare uses $signed or unsigned per SIGNED. No width growth; no arithmetic beyond address increment.
- start while busy or done: ignored.
- Result outputs update only during a scan. They hold their values between scans and after done.

## Timing
- Reset (rst_n=0 at posedge) forces:
  - state IDLE, busy=0, done=0, rd_en=0
  - rd_addr=0, max=0, max_idx=0, second=0, second_idx=0, second_valid=0
  - the pipeline valid bits cleared
- Reset mid-scan aborts immediately; no done is produced.
- start accepted at edge E0. Cycle 1 after E0: busy=1, rd_en=1, rd_addr=base_addr.
- The read of element k is issued in cycle 1+k. Its data is compared in cycle 1+k+RD_LATENCY and registered at the end of that cycle.
- done is high in cycle N+RD_LATENCY+1. busy is low in that same cycle; busy=1 covers cycles 1..N+RD_LATENCY.
- Earliest next accepted start is in cycle N+RD_LATENCY+2, i.e. while back in IDLE.
- Throughput: one element per cycle, with no bubbles inside a scan.
- Wrap: base_addr=250, len=10, ADDR_WIDTH=8 reads 250..255 then 0..3.

## Test plan
- Ramp: RAM[i]=i, base 0, len 0 (256 entries), RD_LATENCY=1 → max=255, max_idx=255, second=254, second_idx=254; done in cycle 258.
- Signed negatives: all -5 except RAM[7]=-2, RAM[9]=-3, SIGNED=1, len 16 → max=-2/7, second=-3/9. With SIGNED=0 on the same data → max=-2 (0xFFFFFFFE) at idx 7, second=-3 at idx 9.
- Ties: RAM[3]=RAM[12]=100, all other entries 1 → max=100, max_idx=3, second=100, second_idx=12.
- Wrap and single entry: base 250, len 10, peak at RAM[2]=50 → max_idx=2. Then base 5, len 1 → max=RAM[5], second_valid=0, done in cycle 1+1+RD_LATENCY.
- Latency sweep RD_LATENCY=1..4, len 8 → done exactly in cycle 9+RD_LATENCY; rd_en high for exactly 8 cycles.
- Handshake abuse: start pulsed during ISSUE is ignored. rst_n=0 mid-scan → all outputs 0, no done. A subsequent start completes normally.
